// File: rtl/phase_speed_est.sv
`default_nettype none
// ============================================================================
//  Module      : phase_speed_est
//  Description : Phase-to-speed estimator. Signed phase samples are summed
//                over a programmable power-of-two window; the window mean is
//                multiplied by a runtime unsigned scale factor, rescaled to
//                the speed fixed-point format and saturated.
//
//  Ports
//    clock_i    : system clock, all logic on the rising edge
//    reset_i    : synchronous active-high reset
//    sample_i   : qualifies phase_i, one sample accepted per cycle when high
//    meanlen_i  : requested log2 window length (clamped to MAXLEN)
//    scale_i    : unsigned scale, UQ(SCALE_W-SCALE_FRAC).SCALE_FRAC
//    phase_i    : signed phase sample, PHASE_FRAC fractional bits
//    speed_o    : saturated signed speed, SPEED_FRAC fractional bits, held
//    valid_o    : one-cycle strobe when speed_o updates
//    sat_o      : speed_o was clamped; updates together with valid_o
//
//  Latency     : last sample of a window at edge k -> speed_o/valid_o at k+3
//  Revision    : 1.0  initial release
// ============================================================================
module phase_speed_est #(
    parameter int PHASE_W    = 19,
    parameter int PHASE_FRAC = 10,
    parameter int SPEED_W    = 16,
    parameter int SPEED_FRAC = 10,
    parameter int SCALE_W    = 16,
    parameter int SCALE_FRAC = 12,
    parameter int MAXLEN     = 10
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      sample_i,
    input  logic [3:0]                meanlen_i,
    input  logic [SCALE_W-1:0]        scale_i,
    input  logic signed [PHASE_W-1:0] phase_i,
    output logic signed [SPEED_W-1:0] speed_o,
    output logic                      valid_o,
    output logic                      sat_o
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    // Accumulator holds up to 2^MAXLEN full-scale samples without overflow.
    localparam int c_ACC_W  = PHASE_W + MAXLEN;
    localparam int c_CNT_W  = (MAXLEN > 0) ? MAXLEN : 1;
    // Mean times {0,scale}: the extra bit keeps scale positive in a signed
    // multiply.
    localparam int c_PROD_W = PHASE_W + SCALE_W + 1;
    // Product carries PHASE_FRAC+SCALE_FRAC fraction bits; drop down to
    // SPEED_FRAC.
    localparam int c_SHIFT  = PHASE_FRAC + SCALE_FRAC - SPEED_FRAC;

    localparam logic [3:0]                c_MAXLEN_L  = 4'(MAXLEN);
    localparam logic signed [SPEED_W-1:0] c_SPEED_MAX = {1'b0, {(SPEED_W-1){1'b1}}};
    localparam logic signed [SPEED_W-1:0] c_SPEED_MIN = {1'b1, {(SPEED_W-1){1'b0}}};

    // ------------------------------------------------------------------------
    // Window accumulation state
    // ------------------------------------------------------------------------
    logic [3:0]                len_q, len_d;
    logic signed [c_ACC_W-1:0] sum_q, sum_d;
    logic [c_CNT_W-1:0]        cnt_q, cnt_d;

    // Completed-window total handed to the averaging stage
    logic                      tot_vld_q, tot_vld_d;
    logic signed [c_ACC_W-1:0] tot_q, tot_d;
    logic [3:0]                tot_len_q, tot_len_d;

    // Stage 1: window mean
    logic                      avg_vld_q, avg_vld_d;
    logic signed [PHASE_W-1:0] avg_q, avg_d;

    // Stage 2: scaled mean
    logic                       prod_vld_q, prod_vld_d;
    logic signed [c_PROD_W-1:0] prod_q, prod_d;

    // Stage 3: saturated output
    logic signed [SPEED_W-1:0] speed_q, speed_d;
    logic                      sat_q, sat_d;
    logic                      valid_q, valid_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [3:0]                 w_len_clamped;
    logic                       w_restart;
    logic signed [c_ACC_W-1:0]  w_sum_base;
    logic [c_CNT_W-1:0]         w_cnt_base;
    logic [c_CNT_W-1:0]         w_last_cnt;
    logic                       w_last;
    logic signed [c_ACC_W-1:0]  w_phase_ext;
    logic signed [c_ACC_W-1:0]  w_total;
    logic signed [c_PROD_W-1:0] w_avg_ext;
    logic signed [c_PROD_W-1:0] w_scale_ext;
    logic signed [c_PROD_W-1:0] w_res;
    logic [c_PROD_W-SPEED_W:0]  w_res_hi;
    logic                       w_in_range;

    // Effective window length and restart detection. A changed length throws
    // away the partial window; the base values below already reflect that,
    // so a sample arriving in the same cycle lands as sample 1 of the new
    // window (and completes it immediately when the new length is 0).
    always_comb begin
        w_len_clamped = (meanlen_i > c_MAXLEN_L) ? c_MAXLEN_L : meanlen_i;
        w_restart     = (w_len_clamped != len_q);
        w_sum_base    = w_restart ? '0 : sum_q;
        w_cnt_base    = w_restart ? '0 : cnt_q;
    end

    // N-1 for the effective window: the low L bits set.
    always_comb begin
        w_last_cnt = '0;
        for (int i = 0; i < c_CNT_W; i++) begin
            w_last_cnt[i] = (i < int'(w_len_clamped));
        end
    end

    always_comb begin
        w_phase_ext = c_ACC_W'(phase_i);
        w_total     = w_sum_base + w_phase_ext;
        w_last      = (w_cnt_base == w_last_cnt);
    end

    // ------------------------------------------------------------------------
    // Accumulator next state
    // ------------------------------------------------------------------------
    always_comb begin
        len_d     = w_len_clamped;
        sum_d     = w_sum_base;
        cnt_d     = w_cnt_base;
        tot_vld_d = 1'b0;
        tot_d     = tot_q;
        tot_len_d = tot_len_q;
        if (sample_i) begin
            if (w_last) begin
                // Window complete: forward the total including this sample
                // and start the next window empty, so back-to-back windows
                // lose nothing.
                sum_d     = '0;
                cnt_d     = '0;
                tot_vld_d = 1'b1;
                tot_d     = w_total;
                tot_len_d = w_len_clamped;
            end else begin
                sum_d = w_total;
                cnt_d = w_cnt_base + c_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: mean = total >>> L. The window length travels with the total
    // so a length change right after completion cannot corrupt it. The sum of
    // 2^L PHASE_W-bit samples divided by 2^L always fits PHASE_W bits.
    // ------------------------------------------------------------------------
    always_comb begin
        avg_vld_d = tot_vld_q;
        avg_d     = avg_q;
        if (tot_vld_q) begin
            avg_d = PHASE_W'(tot_q >>> tot_len_q);
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: scale multiply. scale_i is taken in this cycle, not latched
    // with the window.
    // ------------------------------------------------------------------------
    always_comb begin
        w_avg_ext   = c_PROD_W'(avg_q);
        w_scale_ext = c_PROD_W'({1'b0, scale_i});
        prod_vld_d  = avg_vld_q;
        prod_d      = prod_q;
        if (avg_vld_q) begin
            prod_d = w_avg_ext * w_scale_ext;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 3: rescale and saturate. The shifted result fits SPEED_W signed
    // exactly when every bit from the SPEED_W-1 sign position upward agrees.
    // ------------------------------------------------------------------------
    always_comb begin
        w_res      = prod_q >>> c_SHIFT;
        w_res_hi   = w_res[c_PROD_W-1:SPEED_W-1];
        w_in_range = (&w_res_hi) | ~(|w_res_hi);
        valid_d    = prod_vld_q;
        speed_d    = speed_q;
        sat_d      = sat_q;
        if (prod_vld_q) begin
            if (w_in_range) begin
                speed_d = w_res[SPEED_W-1:0];
                sat_d   = 1'b0;
            end else begin
                speed_d = w_res[c_PROD_W-1] ? c_SPEED_MIN : c_SPEED_MAX;
                sat_d   = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            len_q      <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            tot_vld_q  <= 1'b0;
            tot_q      <= '0;
            tot_len_q  <= '0;
            avg_vld_q  <= 1'b0;
            avg_q      <= '0;
            prod_vld_q <= 1'b0;
            prod_q     <= '0;
            speed_q    <= '0;
            sat_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            len_q      <= len_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            tot_vld_q  <= tot_vld_d;
            tot_q      <= tot_d;
            tot_len_q  <= tot_len_d;
            avg_vld_q  <= avg_vld_d;
            avg_q      <= avg_d;
            prod_vld_q <= prod_vld_d;
            prod_q     <= prod_d;
            speed_q    <= speed_d;
            sat_q      <= sat_d;
            valid_q    <= valid_d;
        end
    end

    assign speed_o = speed_q;
    assign sat_o   = sat_q;
    assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_speed_est.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_speed_est
//  Description : Self-checking bench for phase_speed_est. Directed table of
//                single-sample windows, hand-written multi-cycle sequences
//                and randomized traffic, all compared every cycle against a
//                timestamp-based reference model of the window/mean/scale
//                arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_phase_speed_est;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst     = 1'b1;
    logic               sample  = 1'b0;
    logic [3:0]         meanlen = 4'd0;
    logic [15:0]        scale   = 16'd4096;
    logic signed [18:0] phase   = '0;
    logic signed [15:0] speed;
    logic               valid;
    logic               sat;

    phase_speed_est dut (
        .clock_i   (clk),
        .reset_i   (rst),
        .sample_i  (sample),
        .meanlen_i (meanlen),
        .scale_i   (scale),
        .phase_i   (phase),
        .speed_o   (speed),
        .valid_o   (valid),
        .sat_o     (sat)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;

    logic               obs_valid;
    logic signed [15:0] obs_speed;
    logic               obs_sat;

    int     cur_ml = 0;
    longint cur_sc = 4096;

    // ---------------- reference model ----------------
    typedef struct {
        int     k;
        longint avg;
    } win_t;

    win_t   pend[$];
    int     cyc     = 0;
    int     m_L     = 0;
    longint m_sum   = 0;
    longint m_cnt   = 0;
    bit     s2_v    = 0;
    longint s2_res  = 0;
    bit     m_valid = 0;
    longint m_speed = 0;
    bit     m_sat   = 0;

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_edge();
        int     lc;
        win_t   w;
        if (rst) begin
            m_L = 0; m_sum = 0; m_cnt = 0; pend.delete();
            s2_v = 0; m_valid = 0; m_speed = 0; m_sat = 0;
            cyc++;
            return;
        end
        // Output: result whose window completed three edges ago.
        m_valid = s2_v;
        if (s2_v) begin
            if (s2_res > 32767)       begin m_speed = 32767;  m_sat = 1; end
            else if (s2_res < -32768) begin m_speed = -32768; m_sat = 1; end
            else                      begin m_speed = s2_res; m_sat = 0; end
        end
        // Scale is applied two edges after completion, with its value then.
        s2_v = 0;
        if (pend.size() > 0 && pend[0].k == cyc - 2) begin
            s2_res = fdiv(pend[0].avg * longint'(scale), 4096);
            s2_v   = 1;
            void'(pend.pop_front());
        end
        // Window accumulation.
        lc = (int'(meanlen) > 10) ? 10 : int'(meanlen);
        if (lc != m_L) begin
            m_L = lc; m_sum = 0; m_cnt = 0;
        end
        if (sample) begin
            m_sum += longint'(phase);
            m_cnt++;
            if (m_cnt == (longint'(1) << m_L)) begin
                w.k   = cyc;
                w.avg = fdiv(m_sum, longint'(1) << m_L);
                pend.push_back(w);
                m_sum = 0; m_cnt = 0;
            end
        end
        cyc++;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic observe();
        obs_valid = valid;
        obs_speed = speed;
        obs_sat   = sat;
        if (valid === 1'b1) n_valid++;
        chk("model_valid", longint'(valid), longint'(m_valid));
        chk("model_speed", longint'(speed), m_speed);
        chk("model_sat",   longint'(sat),   longint'(m_sat));
    endtask

    task automatic tick(input bit s, input int ml, input longint sc, input longint ph);
        @(negedge clk);
        rst     = 1'b0;
        sample  = s;
        meanlen = 4'(ml);
        scale   = 16'(sc);
        phase   = 19'(ph);
        cur_ml  = ml;
        cur_sc  = sc;
        @(posedge clk);
        model_edge();
        #1;
        observe();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, cur_ml, cur_sc, 0);
    endtask

    task automatic rst_tick();
        @(negedge clk);
        rst    = 1'b1;
        sample = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        observe();
    endtask

    // ---------------- directed table (meanlen = 0, one sample per window) --
    typedef struct {
        longint sc;
        longint ph;
        longint exp_speed;
        bit     exp_sat;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int v0;
        int rml;
        longint rsc;
        bit     bv[12];
        longint bs[12];
        longint ssum;

        tbl[0]  = '{8192,    20000,  32767, 1'b1};
        tbl[1]  = '{8192,   -20000, -32768, 1'b1};
        tbl[2]  = '{8192,      100,    200, 1'b0};
        tbl[3]  = '{4096,     1536,   1536, 1'b0};
        tbl[4]  = '{4096,       -1,     -1, 1'b0};
        tbl[5]  = '{2048,        3,      1, 1'b0};
        tbl[6]  = '{2048,       -3,     -2, 1'b0};
        tbl[7]  = '{65535,  262143,  32767, 1'b1};
        tbl[8]  = '{65535, -262144, -32768, 1'b1};
        tbl[9]  = '{0,       12345,      0, 1'b0};
        tbl[10] = '{4096,    32767,  32767, 1'b0};
        tbl[11] = '{4096,    32768,  32767, 1'b1};
        tbl[12] = '{4096,   -32768, -32768, 1'b0};
        tbl[13] = '{4096,   -32769, -32768, 1'b1};

        // Reset state
        rst_tick();
        rst_tick();
        chk("reset_valid", longint'(obs_valid), 0);
        chk("reset_speed", longint'(obs_speed), 0);
        chk("reset_sat",   longint'(obs_sat),   0);

        // Nominal mean and exact latency
        for (int i = 0; i < 4; i++) tick(1'b1, 2, 4096, 1536);
        idle(1); chk("nom_k1_valid", longint'(obs_valid), 0);
        idle(1); chk("nom_k2_valid", longint'(obs_valid), 0);
        idle(1); chk("nom_k3_valid", longint'(obs_valid), 1);
        chk("nom_speed", longint'(obs_speed), 1536);
        chk("nom_sat",   longint'(obs_sat),   0);
        idle(1); chk("nom_k4_valid", longint'(obs_valid), 0);
        chk("nom_hold", longint'(obs_speed), 1536);

        // Negative rounding toward -inf
        tick(1'b1, 1, 4096, -1);
        tick(1'b1, 1, 4096, -2);
        idle(3);
        chk("neg_valid", longint'(obs_valid), 1);
        chk("neg_speed", longint'(obs_speed), -2);

        // Table of scale / saturation vectors
        foreach (tbl[i]) begin
            tick(1'b1, 0, tbl[i].sc, tbl[i].ph);
            idle(3);
            chk("tbl_valid", longint'(obs_valid), 1);
            chk("tbl_speed", longint'(obs_speed), tbl[i].exp_speed);
            chk("tbl_sat",   longint'(obs_sat),   longint'(tbl[i].exp_sat));
        end

        // Back-to-back N=1 windows
        for (int j = 0; j < 12; j++) begin
            if (j < 6) tick(1'b1, 0, 4096, j);
            else       idle(1);
            bv[j] = obs_valid;
            bs[j] = longint'(obs_speed);
        end
        for (int j = 0; j < 12; j++) begin
            chk("b2b_valid", longint'(bv[j]), (j >= 3 && j <= 8) ? 1 : 0);
            if (j >= 3 && j <= 8) chk("b2b_speed", bs[j], j - 3);
        end

        // meanlen=1, 8 continuous samples -> 4 results (5,25,45,65)
        v0 = n_valid; ssum = 0;
        for (int j = 0; j < 12; j++) begin
            if (j < 8) tick(1'b1, 1, 4096, 10 * j);
            else       idle(1);
            if (obs_valid) ssum += longint'(obs_speed);
        end
        chk("ml1_count", n_valid - v0, 4);
        chk("ml1_sum", ssum, 140);

        // Window change mid-window discards the partial window
        v0 = n_valid;
        for (int j = 0; j < 5; j++) tick(1'b1, 3, 4096, 1000);
        tick(1'b1, 1, 4096, 200);
        tick(1'b1, 1, 4096, 400);
        idle(5);
        chk("chg_count", n_valid - v0, 1);
        chk("chg_speed", longint'(obs_speed), 300);

        // meanlen=15 clamps to 1024-sample windows
        v0 = n_valid;
        for (int j = 0; j < 1023; j++) tick(1'b1, 15, 4096, 7);
        idle(4);
        chk("clamp_none", n_valid - v0, 0);
        tick(1'b1, 15, 4096, 7);
        idle(3);
        chk("clamp_valid", longint'(obs_valid), 1);
        chk("clamp_speed", longint'(obs_speed), 7);

        // Reset right after a window completes: result is lost
        tick(1'b1, 0, 4096, 500);
        rst_tick();
        v0 = n_valid;
        idle(5);
        chk("rst_novalid", n_valid - v0, 0);
        chk("rst_speed", longint'(obs_speed), 0);
        chk("rst_sat",   longint'(obs_sat),   0);

        // Randomized traffic against the model
        rml = 0; rsc = 4096;
        for (int j = 0; j < 4000; j++) begin
            if ($urandom_range(0, 99) < 4)
                rml = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3))
                                                : int'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 10)
                rsc = longint'($urandom_range(0, 65535));
            if ($urandom_range(0, 999) < 3)
                rst_tick();
            else
                tick($urandom_range(0, 99) < 75, rml, rsc,
                     longint'($urandom_range(0, 524287)) - 262144);
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
